// File: rtl/pa_key_reader_pkg.sv
// rtl/pa_key_reader_pkg.sv - shared constants, FSM encodings and word-count helper for the key reader
package pa_key_pkg;

  localparam int KEY_WORD_W      = 64;
  localparam int ADDR_W          = 15;
  localparam int HALF_WORDS      = 16384;
  localparam int DEF_RD_LAT      = 2;
  localparam int DEF_FIFO_DEPTH  = 4;

  typedef logic [2:0] pa_state_t;

  localparam pa_state_t ST_IDLE  = 3'd0;
  localparam pa_state_t ST_CHECK = 3'd1;
  localparam pa_state_t ST_READ  = 3'd2;
  localparam pa_state_t ST_DRAIN = 3'd3;
  localparam pa_state_t ST_DONE  = 3'd4;
  localparam pa_state_t ST_FAIL  = 3'd5;

  // 33-bit arithmetic keeps lengths near 2^32 from wrapping to a small word count
  function automatic logic [32:0] calc_nwords(input logic [31:0] len_bits);
    return ({1'b0, len_bits} + 33'd63) >> 6;
  endfunction

endpackage

// File: rtl/pa_key_reader_if.sv
// rtl/pa_key_reader_if.sv - key word stream between the reader and key consumers
interface pa_key_reader_if;
  import pa_key_pkg::*;

  logic [KEY_WORD_W-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/pa_key_reader_key_word_fifo.sv
// rtl/pa_key_reader_key_word_fifo.sv - first-word-fall-through buffer absorbing BRAM read latency
module key_word_fifo
  import pa_key_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clock_100M,
  input  logic                    reset,
  input  logic                    i_push,
  input  logic [KEY_WORD_W-1:0]   i_din,
  input  logic                    i_pop,
  output logic [KEY_WORD_W-1:0]   o_dout,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [KEY_WORD_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wp;
  logic [PTR_W-1:0]      r_rp;
  logic [PTR_W:0]        r_count;
  logic                  w_pop;
  logic                  w_full;

  assign w_pop  = i_pop && (r_count != '0);
  assign w_full = (r_count == (PTR_W+1)'(DEPTH));

  always_ff @(posedge clock_100M) begin
    if (i_push) r_mem[r_wp] <= i_din;
  end

  always_ff @(posedge clock_100M or posedge reset) begin
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + PTR_W'(1);
      if (w_pop)  r_rp <= r_rp + PTR_W'(1);
      r_count <= r_count + (PTR_W+1)'(i_push) - (PTR_W+1)'(w_pop);
    end
  end

  assign o_dout  = r_mem[r_rp];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

  // the reader's credit check must make this unreachable
  a_no_overflow: assert property (@(posedge clock_100M) disable iff (reset) !(i_push && w_full));

endmodule

// File: rtl/pa_key_reader.sv
// rtl/pa_key_reader.sv - streams the reconciled key out of BRAM port A; KEY_READER_ZEROIZE_EN wipes consumed words
module pa_key_reader
  import pa_key_pkg::*;
#(
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clock_100M,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           secretkey_length,
  input  logic                  key_addr_index,
  output logic [ADDR_W-1:0]     bram_addra,
  output logic                  bram_ena,
  output logic [KEY_WORD_W-1:0] bram_dina,
  output logic [7:0]            bram_wea,
  input  logic [KEY_WORD_W-1:0] bram_douta,
  pa_key_reader_if.master       m_axis,
  output logic                  busy,
  output logic                  done,
  output logic                  fail
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int RC_W  = ADDR_W + 1;

  pa_state_t           r_state;
  logic [31:0]         r_len;
  logic [32:0]         r_nwords;
  logic [ADDR_W-1:0]   r_base;
  logic [RC_W-1:0]     r_rd_cnt;
  logic [RC_W-1:0]     r_out_cnt;
  logic [RD_LAT-1:0]   r_vld_sr;
  logic [CNT_W-1:0]    r_inflight;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_credit_ok;
  logic                  w_len_err;
  logic                  w_last_word;
  logic                  w_drained;
  logic                  w_zq_full;
  logic                  w_fifo_empty;
  logic [CNT_W-1:0]      w_fifo_count;
  logic [KEY_WORD_W-1:0] w_fifo_dout;
  logic [ADDR_W-1:0]     w_rd_addr;

  assign w_push      = r_vld_sr[RD_LAT-1];
  assign w_pop       = !w_fifo_empty && m_axis.tready;
  assign w_credit_ok = ({1'b0, r_inflight} + {1'b0, w_fifo_count}) < (CNT_W+1)'(FIFO_DEPTH);
  assign w_issue     = (r_state == ST_READ) && (33'(r_rd_cnt) < r_nwords) && w_credit_ok && !w_zq_full;
  assign w_len_err   = (r_len == 32'd0) || (r_nwords > 33'(HALF_WORDS));
  assign w_last_word = (33'(r_out_cnt) == (r_nwords - 33'd1));
  assign w_rd_addr   = r_base + r_rd_cnt[ADDR_W-1:0];

  key_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock_100M (clock_100M),
    .reset      (reset),
    .i_push     (w_push),
    .i_din      (bram_douta),
    .i_pop      (w_pop),
    .o_dout     (w_fifo_dout),
    .o_count    (w_fifo_count),
    .o_empty    (w_fifo_empty)
  );

`ifdef KEY_READER_ZEROIZE_EN
  logic [ADDR_W-1:0] r_zq [4];
  logic [1:0]        r_zq_wp;
  logic [1:0]        r_zq_rp;
  logic [2:0]        r_zq_cnt;
  logic              w_zwr;

  assign w_zq_full = (r_zq_cnt == 3'd4);
  // reads own the port; wipes fill the gaps, and a full queue forces a gap
  assign w_zwr     = (r_zq_cnt != 3'd0) && !w_issue;
  assign w_drained = (33'(r_out_cnt) == r_nwords) && (r_zq_cnt == 3'd0);

  always_ff @(posedge clock_100M) begin
    if (w_pop) r_zq[r_zq_wp] <= r_out_cnt[ADDR_W-1:0];
  end

  always_ff @(posedge clock_100M or posedge reset) begin
    if (reset) begin
      r_zq_wp  <= '0;
      r_zq_rp  <= '0;
      r_zq_cnt <= '0;
    end else begin
      if (w_pop) r_zq_wp <= r_zq_wp + 2'd1;
      if (w_zwr) r_zq_rp <= r_zq_rp + 2'd1;
      r_zq_cnt <= r_zq_cnt + 3'(w_pop) - 3'(w_zwr);
    end
  end

  assign bram_ena   = w_issue || w_zwr;
  assign bram_wea   = w_zwr ? 8'hFF : 8'h00;
  assign bram_dina  = '0;
  assign bram_addra = w_issue ? w_rd_addr : (w_zwr ? (r_base + r_zq[r_zq_rp]) : '0);
`else
  assign w_zq_full  = 1'b0;
  assign w_drained  = (33'(r_out_cnt) == r_nwords) || (w_pop && w_last_word);
  assign bram_ena   = w_issue;
  assign bram_wea   = 8'h00;
  assign bram_dina  = '0;
  assign bram_addra = w_issue ? w_rd_addr : '0;
`endif

  always_ff @(posedge clock_100M or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_nwords   <= '0;
      r_base     <= '0;
      r_rd_cnt   <= '0;
      r_out_cnt  <= '0;
      r_vld_sr   <= '0;
      r_inflight <= '0;
    end else begin
      r_vld_sr   <= (r_vld_sr << 1) | RD_LAT'(w_issue);
      r_inflight <= r_inflight + CNT_W'(w_issue) - CNT_W'(w_push);
      if (w_issue) r_rd_cnt  <= r_rd_cnt + RC_W'(1);
      if (w_pop)   r_out_cnt <= r_out_cnt + RC_W'(1);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_len     <= secretkey_length;
            r_nwords  <= calc_nwords(secretkey_length);
            r_base    <= key_addr_index ? ADDR_W'(HALF_WORDS) : '0;
            r_rd_cnt  <= '0;
            r_out_cnt <= '0;
            r_state   <= ST_CHECK;
          end
        end
        ST_CHECK: r_state <= w_len_err ? ST_FAIL : ST_READ;
        ST_READ:  if (33'(r_rd_cnt) == r_nwords) r_state <= ST_DRAIN;
        ST_DRAIN: if (w_drained) r_state <= ST_DONE;
        ST_DONE:  r_state <= ST_IDLE;
        ST_FAIL:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_axis.tvalid = !w_fifo_empty;
  assign m_axis.tdata  = w_fifo_empty ? '0 : w_fifo_dout;
  assign m_axis.tlast  = !w_fifo_empty && w_last_word;

  assign busy = (r_state == ST_CHECK) || (r_state == ST_READ) || (r_state == ST_DRAIN);
  assign done = (r_state == ST_DONE);
  assign fail = (r_state == ST_FAIL);

endmodule

// File: tb/tb_pa_key_reader.sv
// tb/tb_pa_key_reader.sv - scoreboard bench for pa_key_reader with an address-valued BRAM model
module tb_pa_key_reader;

  logic        clock_100M = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] len = 32'd0;
  logic        idx = 1'b0;
  logic [14:0] bram_addra;
  logic        bram_ena;
  logic [63:0] bram_dina;
  logic [7:0]  bram_wea;
  logic [63:0] bram_douta;
  logic        busy, done, fail;

  pa_key_reader_if m_axis();

  pa_key_reader u_dut (
    .clock_100M       (clock_100M),
    .reset            (reset),
    .start            (start),
    .secretkey_length (len),
    .key_addr_index   (idx),
    .bram_addra       (bram_addra),
    .bram_ena         (bram_ena),
    .bram_dina        (bram_dina),
    .bram_wea         (bram_wea),
    .bram_douta       (bram_douta),
    .m_axis           (m_axis),
    .busy             (busy),
    .done             (done),
    .fail             (fail)
  );

  always #5 clock_100M = ~clock_100M;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clock_100M) cyc++;

  // BRAM port A: two-cycle read, word value equals its address after preload
  logic [63:0] mem [0:32767];
  logic [63:0] p1, p2;
  logic        preload = 1'b1;
  always @(posedge clock_100M) begin
    if (preload) begin
      for (int a = 0; a < 32768; a++) mem[a] <= 64'(a);
    end else if (bram_ena && bram_wea == 8'hFF) begin
      mem[bram_addra] <= bram_dina;
    end
    if (bram_ena && bram_wea == 8'h00) p1 <= mem[bram_addra];
    p2 <= p1;
  end
  assign bram_douta = p2;

  logic rand_rdy = 1'b0;
  logic rdy_fixed = 1'b1;
  always @(posedge clock_100M) begin
    #1;
    m_axis.tready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  logic [64:0] sb[$];
  int acc_cnt, n_done, n_fail, n_ena;
  int t_start, t_first_valid, t_first_acc, t_last_acc, t_done, t_fail, t_last_wr;
  logic busy_at_done;
  logic prev_stall = 1'b0;
  logic [63:0] prev_data;

  always @(negedge clock_100M) begin
    logic [64:0] e;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (start) begin
        t_start = cyc; acc_cnt = 0; t_first_valid = -1; t_first_acc = -1; t_last_acc = -1;
      end
      if (m_axis.tvalid && prev_stall) chk("hold_tdata", m_axis.tdata, prev_data);
      if (m_axis.tvalid && t_first_valid < 0) t_first_valid = cyc;
      if (m_axis.tvalid && m_axis.tready) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_word actual=%0h required=none", m_axis.tdata);
        end else begin
          e = sb.pop_front();
          chk("tdata", m_axis.tdata, e[63:0]);
          chk("tlast", 64'(m_axis.tlast), 64'(e[64]));
        end
        if (acc_cnt == 0) t_first_acc = cyc;
        if (m_axis.tlast) t_last_acc = cyc;
        acc_cnt++;
      end
      prev_stall = m_axis.tvalid && !m_axis.tready;
      prev_data  = m_axis.tdata;
      if (done) begin n_done++; t_done = cyc; busy_at_done = busy; end
      if (fail) begin n_fail++; t_fail = cyc; end
      if (bram_ena) n_ena++;
      if (bram_ena && bram_wea == 8'hFF) t_last_wr = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock_100M);
    #1;
  endtask

  task automatic push_exp(input int base, input int n);
    for (int i = 0; i < n; i++) sb.push_back({(i == n - 1), 64'(base + i)});
  endtask

  task automatic do_start(input logic [31:0] l, input logic ix);
    start = 1'b1; len = l; idx = ix;
    tick(1);
    start = 1'b0;
  endtask

  task automatic reload();
    preload = 1'b1;
    tick(1);
    preload = 1'b0;
  endtask

  task automatic wait_end(input string name, input int budget);
    int base = n_done + n_fail;
    int k = 0;
    while (n_done + n_fail == base && k < budget) begin tick(1); k++; end
    if (k >= budget) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=%0d cycles required=end pulse", name, k);
    end
    tick(2);
  endtask

  task automatic fail_case(input string name, input logic [31:0] l);
    int e0 = n_ena, f0 = n_fail, d0 = n_done;
    do_start(l, 1'b0);
    wait_end(name, 20);
    chk({name, "_fail_lat"}, 64'(t_fail - t_start), 64'd2);
    chk({name, "_fail_cnt"}, 64'(n_fail - f0), 64'd1);
    chk({name, "_no_ena"}, 64'(n_ena - e0), 64'd0);
    chk({name, "_no_done"}, 64'(n_done - d0), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    n_done = 0; n_fail = 0; n_ena = 0; t_last_wr = -1;
    tick(3);
    preload = 1'b0;
    chk("rst_tvalid", 64'(m_axis.tvalid), 64'd0);
    chk("rst_tdata", m_axis.tdata, 64'd0);
    chk("rst_tlast", 64'(m_axis.tlast), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_fail", 64'(fail), 64'd0);
    chk("rst_ena", 64'(bram_ena), 64'd0);
    chk("rst_wea", 64'(bram_wea), 64'd0);
    chk("rst_addra", 64'(bram_addra), 64'd0);
    reset = 1'b0;
    tick(2);

    // 4096 bits from bank 0 with tready held high
    d0 = n_done;
    push_exp(0, 64);
    do_start(32'd4096, 1'b0);
    wait_end("A", 400);
    chk("A_done_cnt", 64'(n_done - d0), 64'd1);
    chk("A_sb_empty", 64'(sb.size()), 64'd0);
    chk("A_first_valid_lat", 64'(t_first_valid - t_start), 64'd5);
    chk("A_busy_at_done", 64'(busy_at_done), 64'd0);
    chk("A_busy_after", 64'(busy), 64'd0);
`ifndef KEY_READER_ZEROIZE_EN
    chk("A_burst_len", 64'(t_last_acc - t_first_acc), 64'd63);
    chk("A_done_after_last", 64'(t_done - t_last_acc), 64'd1);
`endif

    // 100 bits from bank 1: two words
    reload();
    d0 = n_done;
    push_exp(16384, 2);
    do_start(32'd100, 1'b1);
    wait_end("B", 100);
    chk("B_done_cnt", 64'(n_done - d0), 64'd1);
    chk("B_sb_empty", 64'(sb.size()), 64'd0);

    fail_case("C0", 32'd0);
    fail_case("C1", 32'd1048577);
    fail_case("C2", 32'hFFFF_FFFF);

    // full bank 1 ends on the last BRAM address
    reload();
    d0 = n_done;
    push_exp(16384, 16384);
    do_start(32'd1048576, 1'b1);
    wait_end("D", 40000);
    chk("D_done_cnt", 64'(n_done - d0), 64'd1);
    chk("D_sb_empty", 64'(sb.size()), 64'd0);

    // random backpressure
    reload();
    d0 = n_done;
    rand_rdy = 1'b1;
    push_exp(0, 64);
    do_start(32'd4096, 1'b0);
    wait_end("E", 2000);
    rand_rdy = 1'b0;
    tick(2);
    chk("E_done_cnt", 64'(n_done - d0), 64'd1);
    chk("E_sb_empty", 64'(sb.size()), 64'd0);

    // reset in the middle of a stream, then a clean restart
    reload();
    d0 = n_done;
    push_exp(0, 64);
    do_start(32'd4096, 1'b0);
    begin
      int k = 0;
      while (acc_cnt < 20 && k < 200) begin tick(1); k++; end
      if (k >= 200) begin
        checks++; failures++;
        $display("FAIL F_wait20_timeout actual=%0d words required=20", acc_cnt);
      end
    end
    reset = 1'b1;
    #1;
    chk("F_rst_tvalid", 64'(m_axis.tvalid), 64'd0);
    chk("F_rst_tdata", m_axis.tdata, 64'd0);
    chk("F_rst_tlast", 64'(m_axis.tlast), 64'd0);
    chk("F_rst_busy", 64'(busy), 64'd0);
    chk("F_rst_ena", 64'(bram_ena), 64'd0);
    sb.delete();
    tick(2);
    reset = 1'b0;
    tick(2);
    chk("F_no_done_on_abort", 64'(n_done - d0), 64'd0);
    reload();
    push_exp(0, 4);
    do_start(32'd256, 1'b0);
    wait_end("F", 100);
    chk("F_done_cnt", 64'(n_done - d0), 64'd1);
    chk("F_sb_empty", 64'(sb.size()), 64'd0);

`ifdef KEY_READER_ZEROIZE_EN
    reload();
    d0 = n_done;
    push_exp(0, 10);
    do_start(32'd640, 1'b0);
    wait_end("G", 200);
    chk("G_done_cnt", 64'(n_done - d0), 64'd1);
    chk("G_sb_empty", 64'(sb.size()), 64'd0);
    chk("G_done_after_wipe", 64'(t_done > t_last_wr), 64'd1);
    for (int a = 0; a < 10; a++) chk("G_zeroed", mem[a], 64'd0);
    chk("G_untouched", mem[10], 64'd10);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pa_key_reader.md
Name: pa_key_reader

Overview:
Reader end of the Bob secret-key BRAM, the counterpart to the PA writer on port B. After privacy amplification finishes, it reads the reconciled secret key from BRAM port A, one 64-bit word per cycle. It presents the words as an AXI-Stream so the authentication and key-consumer logic can draw key material. It sits in the clock_100M domain next to the PA core and hides the BRAM read latency behind a small credit-tracked FIFO.

Parameters:
ADDR_W, 15, BRAM word address width (depth 32768)
HALF_WORDS, 16384, words per address bank (index 0: 0..16383, index 1: 16384..32767)
RD_LAT, 2, BRAM port A read latency in cycles (1..3)
FIFO_DEPTH, 4, output buffer depth in words (power of 2, at least RD_LAT+1)

Ports:
clock_100M  in  1  system clock
reset  in  1  asynchronous, active-high
start  in  1  single-cycle pulse (PA finish); sampled only in IDLE
secretkey_length  in  32  key length in bits; sampled on start
key_addr_index  in  1  bank select; sampled on start
bram_addra  out  ADDR_W  port A word address
bram_ena  out  1  port A read enable
bram_dina  out  64  write data (zeroize only)
bram_wea  out  8  byte write enables (zeroize only)
bram_douta  in  64  read data, valid RD_LAT cycles after ena
m_tdata  out  64  key word
m_tvalid  out  1  word valid
m_tready  in  1  consumer ready
m_tlast  out  1  final word of the key
busy  out  1  high from accepted start until DONE/FAIL
done  out  1  one-cycle pulse when the last word is accepted
fail  out  1  one-cycle pulse on a length error

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; FIFO empty; counters cleared.
- Word count: nwords = (secretkey_length + 63) >> 6, computed in 33 bits so a length near the 32-bit maximum cannot overflow.
- Length check: length == 0 or nwords > HALF_WORDS → FAIL.
- Base address: key_addr_index ? HALF_WORDS : 0.
- FSM states:
  - IDLE: on start, latch length, index and base; go to CHECK; busy=1.
  - CHECK (1 cycle): length error → FAIL; otherwise → READ.
  - READ: issue a read (ena=1, addra=base+rd_cnt) when rd_cnt < nwords and (inflight + fifo_count) < FIFO_DEPTH. When rd_cnt reaches nwords → DRAIN.
  - DRAIN: wait until all nwords have been accepted on m_* → DONE.
  - DONE: pulse done for 1 cycle; busy=0; → IDLE.
  - FAIL: pulse fail for 1 cycle; busy=0; no BRAM access; → IDLE.
- inflight is the count of reads issued but not yet returned. It uses a RD_LAT-deep valid shift register; returned data is pushed into the FIFO.
- Credit rule: the FIFO never overflows; a push into a full FIFO is an assertion failure.
- AXI-Stream rules:
  - m_tvalid = FIFO not empty.
  - A word transfers when tvalid && tready.
  - m_tdata and m_tvalid hold stable while tready=0.
  - m_tlast = 1 on the word whose out_cnt == nwords-1.
- Throughput: 1 word/cycle with tready held high. First m_tvalid appears RD_LAT+1 cycles after entering READ.
- Simultaneous push and pop: allowed; count unchanged.
- start while busy: ignored.
- nwords == 1: the single word carries tlast; done pulses the cycle after it is accepted.
- Addresses never wrap past base+nwords-1; bank 1 with nwords == HALF_WORDS ends at address 32767.
- Reset mid-operation: immediate return to IDLE; FIFO and in-flight tracking flushed; no done pulse.
- Without zeroize: bram_wea = 0 and bram_dina = 0 at all times.

Optional Feature:
KEY_READER_ZEROIZE_EN:
- Defined: each word accepted on m_* is overwritten with zeros in BRAM, so consumed key material is never reused.
- Read has priority on port A. A zero-write (ena=1, wea=8'hFF, dina=0, addra=base+out_index) uses a cycle with no read issued, from a 4-entry pending-address queue.
- The read issue is stalled when that queue is full.
- DONE is entered only once the queue is empty.
- Undefined: no write logic; outputs as stated above.

Decomposition:
- Package pa_key_pkg:
  - FSM state enum (IDLE, CHECK, READ, DRAIN, DONE, FAIL)
  - KEY_WORD_W=64
  - ADDR_W
  - HALF_WORDS
- One sub-module, key_word_fifo: synchronous FIFO with FIFO_DEPTH entries of 64 bits, count output and first-word-fall-through read.

Test Plan:
- BRAM preloaded with addr value in every word; length=4096, index=0, tready=1 → 64 words 0..63 on consecutive cycles after latency; tlast on word 63; done one cycle later; busy low.
- length=100, index=1 → 2 words (16384, 16385); tlast on the second word.
- length=0 → fail pulse two cycles after start, no ena asserted; length=1048577 → fail.
- length=4096, tready toggled at random 50% → all 64 words in order, no loss or duplication, data stable while stalled, FIFO never overflows.
- Reset asserted mid-stream at word 20 → outputs 0 immediately; a new start then streams from word 0 correctly.
- With KEY_READER_ZEROIZE_EN and length=640 → 10 words streamed; BRAM addresses 0..9 read back as 0 afterwards; done only after the last zero-write.
